// File: rtl/spi_nslv_regbank.sv
// Serial frame decoder fronting NUM_SLV small register files; reads load a
// per-slave DAC output word and stream the register value back on miso.
module spi_nslv_regbank #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                      sclk,
    input  logic                      reset,
    input  logic                      cs,
    input  logic                      mosi,
    output logic                      miso,
    output logic [NUM_SLV*DATA_W-1:0] dac_op,
    output logic                      frame_done,
    output logic                      addr_err
);

    localparam int unsigned SLV_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned MAX_AS = (SLV_W > ADDR_W) ? SLV_W : ADDR_W;
    localparam int unsigned MAX_F  = (MAX_AS > DATA_W) ? MAX_AS : DATA_W;
    localparam int unsigned CNT_W  = (MAX_F > 1) ? $clog2(MAX_F) : 1;
    localparam int unsigned NREG   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_RW,
        S_SLV,
        S_REG,
        S_WDATA,
        S_RDATA
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [SLV_W-1:0]    slv_q, slv_d;
    logic [ADDR_W-1:0]   reg_q, reg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rd_shift_q, rd_shift_d;
    logic                miso_d, done_d, err_d;
    logic                wr_en, rd_load, slv_ok;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   regs  [NUM_SLV][NREG];
    logic [DATA_W-1:0]   dac_q [NUM_SLV];

    assign slv_ok  = (32'(slv_q) < NUM_SLV);
    assign rd_word = slv_ok ? regs[slv_q][reg_d] : '0;

    // Next-state and field assembly; cs high flushes any partial frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        slv_d      = slv_q;
        reg_d      = reg_q;
        data_d     = data_q;
        rd_shift_d = rd_shift_q;
        miso_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        rd_load    = 1'b0;
        if (cs) begin
            state_d    = S_RW;
            cnt_d      = '0;
            rw_d       = 1'b0;
            slv_d      = '0;
            reg_d      = '0;
            data_d     = '0;
            rd_shift_d = '0;
        end else begin
            case (state_q)
                S_RW: begin
                    rw_d    = mosi;
                    cnt_d   = '0;
                    state_d = S_SLV;
                end
                S_SLV: begin
                    slv_d = SLV_W'({slv_q, mosi});
                    if (cnt_q == CNT_W'(SLV_W - 1)) begin
                        cnt_d   = '0;
                        state_d = S_REG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REG: begin
                    reg_d = ADDR_W'({reg_q, mosi});
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d    = S_RDATA;
                            rd_load    = slv_ok;
                            rd_shift_d = rd_word;
                            miso_d     = rd_word[DATA_W-1];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WDATA: begin
                    data_d = DATA_W'({data_q, mosi});
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        wr_en   = slv_ok;
                        done_d  = 1'b1;
                        err_d   = !slv_ok;
                        state_d = S_RW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RDATA: begin
                    // Shifted-out word empties exactly as the frame ends, so miso returns to 0.
                    rd_shift_d = rd_shift_q << 1;
                    miso_d     = rd_shift_d[DATA_W-1];
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        err_d   = !slv_ok;
                        state_d = S_RW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_RW;
            endcase
        end
    end

    // State, datapath and register-file storage.
    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q    <= S_RW;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            slv_q      <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            rd_shift_q <= '0;
            miso       <= 1'b0;
            frame_done <= 1'b0;
            addr_err   <= 1'b0;
            for (int s = 0; s < int'(NUM_SLV); s++) begin
                dac_q[s] <= '0;
                for (int r = 0; r < int'(NREG); r++) begin
                    regs[s][r] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            slv_q      <= slv_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            rd_shift_q <= rd_shift_d;
            miso       <= miso_d;
            frame_done <= done_d;
            addr_err   <= err_d;
            if (wr_en) begin
                regs[slv_q][reg_q] <= data_d;
            end
            if (rd_load) begin
                dac_q[slv_q] <= rd_word;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_SLV); k++) begin : g_dac
        assign dac_op[k*DATA_W +: DATA_W] = dac_q[k];
    end

endmodule
